// File: rtl/tl_a_prot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tl_a_prot_arbiter
// Purpose  : Round-robin TileLink A-channel arbiter that holds its grant
//            across stalls and bursts and carries the 7-bit AMBA prot field.
// Revision : 1.0 - initial release
// ============================================================================
module tl_a_prot_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 3,
    parameter int SRC_W  = 2,
    parameter int IDX_W  = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          in_a_valid,
    output logic [N_REQ-1:0]          in_a_ready,
    input  logic [3*N_REQ-1:0]        in_a_opcode,
    input  logic [3*N_REQ-1:0]        in_a_param,
    input  logic [SIZE_W*N_REQ-1:0]   in_a_size,
    input  logic [SRC_W*N_REQ-1:0]    in_a_source,
    input  logic [ADDR_W*N_REQ-1:0]   in_a_address,
    input  logic [DATA_W/8*N_REQ-1:0] in_a_mask,
    input  logic [DATA_W*N_REQ-1:0]   in_a_data,
    input  logic [7*N_REQ-1:0]        in_a_prot,
    output logic                      out_a_valid,
    input  logic                      out_a_ready,
    output logic [2:0]                out_a_opcode,
    output logic [2:0]                out_a_param,
    output logic [SIZE_W-1:0]         out_a_size,
    output logic [IDX_W+SRC_W-1:0]    out_a_source,
    output logic [ADDR_W-1:0]         out_a_address,
    output logic [DATA_W/8-1:0]       out_a_mask,
    output logic [DATA_W-1:0]         out_a_data,
    output logic [6:0]                out_a_prot,
    output logic                      prot_err,
    input  logic                      prot_err_clr
);

    localparam int BB   = DATA_W / 8;
    localparam int LGBB = $clog2(BB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [IDX_W-1:0]   r_gidx, w_gidx_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [7:0]         r_beat_cnt, w_beat_nxt;
    logic               r_prot_err, w_prot_err_nxt;
    logic [6:0]         r_first_prot;
    logic [SRC_W-1:0]   r_first_src;
    logic [SIZE_W-1:0]  r_first_size;

    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_found;
    logic [IDX_W-1:0]   w_sel;
    logic [N_REQ-1:0]   w_grant;
    logic [SRC_W-1:0]   w_src_sel;
    logic               w_fire;
    logic               w_multi;
    logic [7:0]         w_beats_m1;
    logic               w_latch;
    logic               w_mismatch;

    function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] i);
        f_next_idx = (int'(i) == N_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        int idx;
        idx         = 0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_arb_found && in_a_valid[idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IDX_W'(idx);
            end
        end
    end

    assign w_sel   = (r_state == S_IDLE) ? w_arb_idx : r_gidx;
    assign w_grant = (r_state == S_IDLE) ?
                     (w_arb_found ? (N_REQ'(1) << w_arb_idx) : '0) : r_grant;

    assign out_a_opcode  = in_a_opcode[3*int'(w_sel) +: 3];
    assign out_a_param   = in_a_param[3*int'(w_sel) +: 3];
    assign out_a_size    = in_a_size[SIZE_W*int'(w_sel) +: SIZE_W];
    assign w_src_sel     = in_a_source[SRC_W*int'(w_sel) +: SRC_W];
    assign out_a_source  = {w_sel, w_src_sel};
    assign out_a_address = in_a_address[ADDR_W*int'(w_sel) +: ADDR_W];
    assign out_a_mask    = in_a_mask[BB*int'(w_sel) +: BB];
    assign out_a_data    = in_a_data[DATA_W*int'(w_sel) +: DATA_W];
    assign out_a_prot    = in_a_prot[7*int'(w_sel) +: 7];

    // Handshakes are forced low while reset is held, including mid-cycle.
    assign out_a_valid = ~reset & ((r_state == S_IDLE) ? |in_a_valid : in_a_valid[r_gidx]);
    assign in_a_ready  = reset ? '0 : ({N_REQ{out_a_ready}} & w_grant);
    assign w_fire      = out_a_valid & out_a_ready;
    assign prot_err    = r_prot_err;

    assign w_multi = ~out_a_opcode[2] && (int'(out_a_size) > LGBB);

    always_comb begin
        w_beats_m1 = '0;
        if (w_multi)
            w_beats_m1 = 8'((9'd1 << (int'(out_a_size) - LGBB)) - 9'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gidx_nxt  = r_gidx;
        w_grant_nxt = r_grant;
        w_beat_nxt  = r_beat_cnt;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_found) begin
                    w_gidx_nxt  = w_arb_idx;
                    w_grant_nxt = w_grant;
                    if (!w_fire) begin
                        w_state_nxt = S_HOLD;
                    end else if (w_multi) begin
                        w_state_nxt = S_BURST;
                        w_beat_nxt  = w_beats_m1;
                        w_latch     = 1'b1;
                    end else begin
                        w_rr_nxt    = f_next_idx(w_arb_idx);
                        w_grant_nxt = '0;
                    end
                end
            end
            S_HOLD: begin
                if (w_fire) begin
                    if (w_multi) begin
                        w_state_nxt = S_BURST;
                        w_beat_nxt  = w_beats_m1;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = f_next_idx(r_gidx);
                        w_grant_nxt = '0;
                    end
                end
            end
            S_BURST: begin
                if (w_fire) begin
                    w_beat_nxt = r_beat_cnt - 8'd1;
                    if (r_beat_cnt == 8'd1) begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = f_next_idx(r_gidx);
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Only presented beats are compared; bubbles carry no meaningful payload.
    assign w_mismatch = (r_state == S_BURST) && in_a_valid[r_gidx] &&
                        ((out_a_prot != r_first_prot) ||
                         (w_src_sel  != r_first_src)  ||
                         (out_a_size != r_first_size));

    assign w_prot_err_nxt = prot_err_clr ? 1'b0 : (r_prot_err | w_mismatch);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_gidx       <= '0;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_prot_err   <= 1'b0;
            r_first_prot <= '0;
            r_first_src  <= '0;
            r_first_size <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_grant    <= w_grant_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_prot_err <= w_prot_err_nxt;
            if (w_latch) begin
                r_first_prot <= out_a_prot;
                r_first_src  <= w_src_sel;
                r_first_size <= out_a_size;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_a_prot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_a_prot_arbiter
// Purpose  : Directed self-checking bench for tl_a_prot_arbiter (N_REQ=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_a_prot_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  in_a_valid;
    logic [1:0]  in_a_ready;
    logic [5:0]  in_a_opcode;
    logic [5:0]  in_a_param;
    logic [5:0]  in_a_size;
    logic [3:0]  in_a_source;
    logic [63:0] in_a_address;
    logic [7:0]  in_a_mask;
    logic [63:0] in_a_data;
    logic [13:0] in_a_prot;
    logic        out_a_valid;
    logic        out_a_ready;
    logic [2:0]  out_a_opcode;
    logic [2:0]  out_a_param;
    logic [2:0]  out_a_size;
    logic [2:0]  out_a_source;
    logic [31:0] out_a_address;
    logic [3:0]  out_a_mask;
    logic [31:0] out_a_data;
    logic [6:0]  out_a_prot;
    logic        prot_err;
    logic        prot_err_clr;

    int n_total = 0;
    int n_bad   = 0;

    tl_a_prot_arbiter #(
        .N_REQ(2), .ADDR_W(32), .DATA_W(32), .SIZE_W(3), .SRC_W(2), .IDX_W(1)
    ) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_opcode(in_a_opcode), .in_a_param(in_a_param),
        .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask),
        .in_a_data(in_a_data), .in_a_prot(in_a_prot),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
        .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask),
        .out_a_data(out_a_data), .out_a_prot(out_a_prot),
        .prot_err(prot_err), .prot_err_clr(prot_err_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [2:0] sz, input logic [1:0] src,
                           input logic [31:0] addr, input logic [6:0] prot);
        in_a_valid[i]          = v;
        in_a_opcode[3*i +: 3]  = op;
        in_a_param[3*i +: 3]   = 3'd0;
        in_a_size[3*i +: 3]    = sz;
        in_a_source[2*i +: 2]  = src;
        in_a_address[32*i +: 32] = addr;
        in_a_mask[4*i +: 4]    = 4'hF;
        in_a_data[32*i +: 32]  = addr ^ 32'hDEAD_0000;
        in_a_prot[7*i +: 7]    = prot;
    endtask

    initial begin
        reset        = 1'b1;
        out_a_ready  = 1'b1;
        prot_err_clr = 1'b0;
        in_a_valid   = '0;
        in_a_opcode  = '0; in_a_param = '0; in_a_size = '0; in_a_source = '0;
        in_a_address = '0; in_a_mask  = '0; in_a_data = '0; in_a_prot   = '0;
        set_req(0, 1'b1, 3'd4, 3'd2, 2'd1, 32'h100, 7'h00);
        set_req(1, 1'b1, 3'd4, 3'd2, 2'd2, 32'h200, 7'h00);
        #2;
        chk("rst_valid", 64'(out_a_valid), 64'h0);
        chk("rst_ready", 64'(in_a_ready), 64'h0);
        chk("rst_err",   64'(prot_err),   64'h0);
        tick;
        tick;
        reset = 1'b0;

        // Alternating single-beat Gets
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t1_ready", 64'(in_a_ready),    (c % 2 == 0) ? 64'h1 : 64'h2);
            chk("t1_src",   64'(out_a_source),  (c % 2 == 0) ? 64'h1 : 64'h6);
            chk("t1_addr",  64'(out_a_address), (c % 2 == 0) ? 64'h100 : 64'h200);
            tick;
        end

        // 4-beat PutFull burst from req0 while req1 waits
        set_req(0, 1'b1, 3'd0, 3'd4, 2'd3, 32'h300, 7'h11);
        for (int b = 0; b < 4; b++) begin
            in_a_data[31:0] = 32'hD0 + 32'(b);
            #1;
            chk("t2_ready", 64'(in_a_ready), 64'h1);
            chk("t2_prot",  64'(out_a_prot), 64'h11);
            chk("t2_data",  64'(out_a_data), 64'hD0 + 64'(b));
            tick;
        end
        #1;
        chk("t2_next_ready", 64'(in_a_ready),   64'h2);
        chk("t2_next_src",   64'(out_a_source), 64'h6);
        chk("t2_err",        64'(prot_err),     64'h0);
        tick;
        in_a_valid = '0;

        // Stalled req1 holds grant while req0 raises valid
        out_a_ready = 1'b0;
        set_req(1, 1'b1, 3'd4, 3'd2, 2'd2, 32'hA0, 7'h44);
        #1;
        chk("t3_valid", 64'(out_a_valid), 64'h1);
        chk("t3_ready", 64'(in_a_ready),  64'h0);
        tick;
        set_req(0, 1'b1, 3'd4, 3'd2, 2'd1, 32'h100, 7'h00);
        for (int s = 0; s < 2; s++) begin
            #1;
            chk("t3_hold_src",  64'(out_a_source),  64'h6);
            chk("t3_hold_addr", 64'(out_a_address), 64'hA0);
            chk("t3_hold_prot", 64'(out_a_prot),    64'h44);
            tick;
        end
        out_a_ready = 1'b1;
        #1;
        chk("t3_fire_ready", 64'(in_a_ready), 64'h2);
        tick;
        #1;
        chk("t3_next_ready", 64'(in_a_ready), 64'h1);
        tick;
        in_a_valid = '0;

        // Prot change inside a 2-beat burst; sticky error and clear priority
        set_req(0, 1'b1, 3'd0, 3'd3, 2'd0, 32'h400, 7'h02);
        #1;
        chk("t4_ready", 64'(in_a_ready), 64'h1);
        tick;
        in_a_prot[6:0] = 7'h03;
        #1;
        chk("t4_err_before", 64'(prot_err), 64'h0);
        tick;
        in_a_valid = '0;
        #1;
        chk("t4_err_set", 64'(prot_err), 64'h1);
        tick;
        #1;
        chk("t4_err_sticky", 64'(prot_err), 64'h1);
        prot_err_clr = 1'b1;
        tick;
        prot_err_clr = 1'b0;
        #1;
        chk("t4_err_clr", 64'(prot_err), 64'h0);
        set_req(0, 1'b1, 3'd0, 3'd3, 2'd0, 32'h400, 7'h02);
        tick;
        in_a_prot[6:0] = 7'h03;
        prot_err_clr   = 1'b1;
        tick;
        prot_err_clr = 1'b0;
        in_a_valid   = '0;
        #1;
        chk("t4_clr_wins", 64'(prot_err), 64'h0);

        // Reset in the middle of a 4-beat burst
        set_req(0, 1'b1, 3'd0, 3'd4, 2'd0, 32'h500, 7'h01);
        #1;
        chk("t5_ready", 64'(in_a_ready), 64'h1);
        tick;
        tick;
        reset = 1'b1;
        set_req(1, 1'b1, 3'd4, 3'd2, 2'd2, 32'h200, 7'h00);
        #1;
        chk("t5_rst_valid", 64'(out_a_valid), 64'h0);
        chk("t5_rst_ready", 64'(in_a_ready),  64'h0);
        tick;
        reset = 1'b0;
        set_req(0, 1'b1, 3'd4, 3'd2, 2'd1, 32'h100, 7'h00);
        #1;
        chk("t5_after_ready", 64'(in_a_ready), 64'h1);
        chk("t5_after_src",   64'(out_a_source), 64'h1);
        tick;
        in_a_valid = '0;

        // Single Logical beat from req1, zero latency
        set_req(1, 1'b1, 3'd3, 3'd2, 2'd3, 32'h600, 7'h5A);
        #1;
        chk("t6_valid",  64'(out_a_valid),  64'h1);
        chk("t6_ready",  64'(in_a_ready),   64'h2);
        chk("t6_prot",   64'(out_a_prot),   64'h5A);
        chk("t6_opcode", 64'(out_a_opcode), 64'h3);
        chk("t6_src",    64'(out_a_source), 64'h7);
        tick;
        set_req(0, 1'b1, 3'd4, 3'd2, 2'd1, 32'h100, 7'h00);
        #1;
        chk("t6_rearb", 64'(in_a_ready), 64'h1);
        tick;
        in_a_valid = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
